// File: rtl/layer1_pool_window_feeder_pkg.sv
// Shared constants, FSM encoding and window-slice helper for the
// layer-1 pool stage (feeder and pool top).
package layer1_pool_window_feeder_pkg;

    localparam int bits        = 16;
    localparam int bits_shift  = 4;
    localparam int channel_num = 16;
    localparam int IMG_W       = 28;
    localparam int IMG_H       = 28;

    typedef enum logic [1:0] {
        EVEN_ROW = 2'd0,
        ODD_ROW  = 2'd1,
        WAIT     = 2'd2
    } state_t;

    // Bit offset of channel ch inside a packed 2x2 window of
    // w-bit values (four values per channel).
    function automatic int win_slice_off(input int ch, input int w);
        return ch * 4 * w;
    endfunction

endpackage

// File: rtl/layer1_pool_window_feeder_line_buffer.sv
// One-row pixel buffer: single write port, two asynchronous read ports.
// Ports: clk_in, we/waddr/wdata (write), raddr_a/rdata_a, raddr_b/rdata_b.
module pool_line_buffer #(
    parameter int DEPTH     = 28,
    parameter int WIDTH     = 256,
    parameter int ADDR_BITS = 5
) (
    input  logic                 clk_in,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_BITS-1:0] raddr_a,
    input  logic [ADDR_BITS-1:0] raddr_b,
    output logic [WIDTH-1:0]     rdata_a,
    output logic [WIDTH-1:0]     rdata_b
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents carry no reset; they are rewritten every even row.
    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/layer1_pool_window_feeder.sv
// Buffers one image row and emits non-overlapping 2x2 windows to the
// layer-1 max-pool array, one start pulse per window, held until ready.
// Ports: clk_in, rst_n (sync, active-low); pix_in/pix_valid/pix_ready
// pixel stream in; win_data/start/pool_ready window handshake out;
// frame_done pulses after the last window of a frame.
module layer1_pool_window_feeder #(
    parameter int bits        = layer1_pool_window_feeder_pkg::bits,
    parameter int bits_shift  = layer1_pool_window_feeder_pkg::bits_shift,
    parameter int channel_num = layer1_pool_window_feeder_pkg::channel_num,
    parameter int IMG_W       = layer1_pool_window_feeder_pkg::IMG_W,
    parameter int IMG_H       = layer1_pool_window_feeder_pkg::IMG_H,
    parameter int col_bits    = 5,
    parameter int row_bits    = 5
) (
    input  logic                                    clk_in,
    input  logic                                    rst_n,
    input  logic [(channel_num<<bits_shift)-1:0]    pix_in,
    input  logic                                    pix_valid,
    output logic                                    pix_ready,
    output logic [(channel_num<<(bits_shift+2))-1:0] win_data,
    output logic                                    start,
    input  logic                                    pool_ready,
    output logic                                    frame_done
);

    import layer1_pool_window_feeder_pkg::*;

    localparam int PIX_W = channel_num << bits_shift;
    localparam int WIN_W = channel_num << (bits_shift + 2);

    localparam logic [col_bits-1:0] COL_LAST = col_bits'(IMG_W - 1);
    localparam logic [row_bits-1:0] ROW_LAST = row_bits'(IMG_H - 1);

    state_t               state_q;
    state_t               state_d;
    logic [col_bits-1:0]  col_q;
    logic [row_bits-1:0]  row_q;
    logic [PIX_W-1:0]     left_q;
    logic [WIN_W-1:0]     win_q;
    logic [WIN_W-1:0]     win_next;
    logic                 start_q;
    logic                 done_q;
    logic                 done_d;
    logic                 win_load;
    logic                 accept;
    logic [PIX_W-1:0]     rd_prev;
    logic [PIX_W-1:0]     rd_cur;
    logic [col_bits-1:0]  col_prev;

    assign col_prev = col_q - col_bits'(1);

    pool_line_buffer #(
        .DEPTH     (IMG_W),
        .WIDTH     (PIX_W),
        .ADDR_BITS (col_bits)
    ) u_line_buffer (
        .clk_in  (clk_in),
        .we      (accept & ~row_q[0]),
        .waddr   (col_q),
        .wdata   (pix_in),
        .raddr_a (col_prev),
        .raddr_b (col_q),
        .rdata_a (rd_prev),
        .rdata_b (rd_cur)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q <= EVEN_ROW;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters have already advanced past the window's beat when WAIT
    // resolves, so col==0 means the window closed a row and
    // col==0 && row==0 means it closed the frame.
    always_comb begin
        state_d   = state_q;
        pix_ready = rst_n && (state_q != WAIT);
        accept    = pix_valid && pix_ready;
        win_load  = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            EVEN_ROW: begin
                if (accept && (col_q == COL_LAST)) begin
                    state_d = ODD_ROW;
                end
            end
            ODD_ROW: begin
                if (accept && col_q[0]) begin
                    state_d  = WAIT;
                    win_load = 1'b1;
                end
            end
            WAIT: begin
                if (pool_ready) begin
                    if (col_q == '0) begin
                        state_d = EVEN_ROW;
                        done_d  = (row_q == '0);
                    end else begin
                        state_d = ODD_ROW;
                    end
                end
            end
            default: begin
                state_d = EVEN_ROW;
            end
        endcase
    end

    // Per channel, LSB first: TL, TR, BL, BR.
    always_comb begin
        win_next = '0;
        for (int c = 0; c < channel_num; c++) begin
            win_next[win_slice_off(c, bits) +: 4*bits] = {
                pix_in[c*bits +: bits],
                left_q[c*bits +: bits],
                rd_cur[c*bits +: bits],
                rd_prev[c*bits +: bits]
            };
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (col_q == COL_LAST) begin
                col_q <= '0;
                row_q <= (row_q == ROW_LAST) ? '0 : row_q + row_bits'(1);
            end else begin
                col_q <= col_q + col_bits'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            left_q <= '0;
        end else if (accept && row_q[0] && !col_q[0]) begin
            left_q <= pix_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            win_q   <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            start_q <= win_load;
            done_q  <= done_d;
            if (win_load) begin
                win_q <= win_next;
            end
        end
    end

    assign win_data   = win_q;
    assign start      = start_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_layer1_pool_window_feeder.sv
// Directed bench for layer1_pool_window_feeder on a 4x4 image.
// Pixel (r,c) channel k carries (r<<8)|(c<<4)|k.
module tb_layer1_pool_window_feeder;

    localparam int W = 4;
    localparam int H = 4;

    logic          clk_in = 1'b0;
    logic          rst_n = 1'b0;
    logic [255:0]  pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [1023:0] win_data;
    logic          start;
    logic          pool_ready = 1'b0;
    logic          frame_done;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    int done_cnt = 0;

    always #5 clk_in = ~clk_in;

    layer1_pool_window_feeder #(
        .IMG_W    (W),
        .IMG_H    (H),
        .col_bits (2),
        .row_bits (2)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .win_data   (win_data),
        .start      (start),
        .pool_ready (pool_ready),
        .frame_done (frame_done)
    );

    always @(posedge clk_in) begin
        if (start) start_cnt++;
        if (frame_done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [1023:0] obs,
                         input logic [1023:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [15:0] pv(input int r, input int c, input int k);
        return 16'((r << 8) | (c << 4) | k);
    endfunction

    function automatic logic [255:0] pix(input int r, input int c);
        logic [255:0] p;
        p = '0;
        for (int k = 0; k < 16; k++) p[k*16 +: 16] = pv(r, c, k);
        return p;
    endfunction

    function automatic logic [1023:0] exp_win(input int r, input int c);
        logic [1023:0] w;
        w = '0;
        for (int k = 0; k < 16; k++)
            w[k*64 +: 64] = {pv(r+1, c+1, k), pv(r+1, c, k),
                             pv(r, c+1, k), pv(r, c, k)};
        return w;
    endfunction

    // Streams one frame; serves each window after `delay` stall cycles.
    // stop_after>0 returns in the start cycle of that window (left in WAIT).
    task automatic send_frame(input int delay, input bit gaps,
                              input int stop_after);
        int w;
        int n;
        int g;
        logic [1023:0] held;
        logic [63:0] s;
        w = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gaps) begin
                    g = int'($urandom_range(0, 2));
                    repeat (g) step();
                end
                pix_in = pix(r, c);
                pix_valid = 1'b1;
                n = 0;
                while (!pix_ready && n < 50) begin
                    step();
                    n++;
                end
                if (n == 50) check("accept_timeout", 0, 1);
                step();
                pix_valid = 1'b0;
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    check("start", start, 1);
                    check("win", win_data, exp_win(r-1, c-1));
                    if (w == 0) begin
                        s = win_data[63:0];
                        check("win0_ch0", s, 64'h0110_0100_0010_0000);
                    end
                    if (w == 3) begin
                        s = win_data[1023:960];
                        check("win3_ch15", s, 64'h033F_032F_023F_022F);
                    end
                    w++;
                    if (w == stop_after) return;
                    held = win_data;
                    for (int i = 0; i < delay; i++) begin
                        check("stall_ready", pix_ready, 0);
                        check("hold", win_data, held);
                        step();
                    end
                    pool_ready = 1'b1;
                    step();
                    pool_ready = 1'b0;
                    check("resume", pix_ready, 1);
                    check("frame_done", frame_done, (w == 4));
                end
            end
        end
    endtask

    initial begin
        int s0;
        int d0;

        // reset
        rst_n = 1'b0;
        step();
        step();
        check("rst_ready", pix_ready, 0);
        check("rst_start", start, 0);
        check("rst_win", win_data, 0);
        check("rst_done", frame_done, 0);
        rst_n = 1'b1;
        #1;
        check("rel_ready", pix_ready, 1);

        // full frame, ready one cycle after start
        s0 = start_cnt;
        d0 = done_cnt;
        send_frame(1, 1'b0, 0);
        step();
        check("f1_starts", start_cnt - s0, 4);
        check("f1_dones", done_cnt - d0, 1);

        // ready delayed 5 cycles
        s0 = start_cnt;
        d0 = done_cnt;
        send_frame(5, 1'b0, 0);
        step();
        check("f2_starts", start_cnt - s0, 4);
        check("f2_dones", done_cnt - d0, 1);

        // random valid gaps, ready in the start cycle
        s0 = start_cnt;
        send_frame(0, 1'b1, 0);
        step();
        check("f3_starts", start_cnt - s0, 4);

        // reset while waiting on window 2
        send_frame(1, 1'b0, 2);
        rst_n = 1'b0;
        step();
        check("mid_rst_start", start, 0);
        check("mid_rst_win", win_data, 0);
        check("mid_rst_ready", pix_ready, 0);
        check("mid_rst_done", frame_done, 0);
        rst_n = 1'b1;
        s0 = start_cnt;
        d0 = done_cnt;
        repeat (5) step();
        check("post_rst_nostart", start_cnt - s0, 0);
        check("post_rst_ready", pix_ready, 1);
        send_frame(1, 1'b0, 0);
        step();
        check("f4_starts", start_cnt - s0, 4);
        check("f4_dones", done_cnt - d0, 1);

        // ready pulses while idle in EVEN_ROW
        s0 = start_cnt;
        pool_ready = 1'b1;
        repeat (3) step();
        pool_ready = 1'b0;
        check("idle_nostart", start_cnt - s0, 0);
        check("idle_ready", pix_ready, 1);
        check("idle_start", start, 0);

        // two back-to-back frames
        s0 = start_cnt;
        d0 = done_cnt;
        send_frame(1, 1'b0, 0);
        send_frame(1, 1'b0, 0);
        step();
        check("b2b_starts", start_cnt - s0, 8);
        check("b2b_dones", done_cnt - d0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
